patch_store_multi: RTL and testbench

Multi-slot successor to the single-address patch injector on the RAM tracer. Holds NUM_SLOTS programmable trigger addresses and a shared patch-data RAM, both loaded through config register writes. When a burst address matches an enabled slot, it asserts patch_trigger. It then streams that slot's programmed words as fake RAM read data, advancing on patch_data_next.

---
 rtl/patch_store_multi.sv | 161 ++++++++++++++++
 tb/tb_patch_store_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/patch_store_multi.sv
// patch_store_multi: multi-slot RAM-read patch injector.
// Holds NUM_SLOTS trigger addresses and a shared patch RAM, both loaded through
// config writes. A strobed burst address matching an enabled slot raises
// patch_trigger. The block then streams that slot's words on patch_data,
// advancing on patch_data_next. FILL_WORD is returned once the words run out.
module patch_store_multi #(
  parameter int                    NUM_SLOTS  = 4,
  parameter int                    ADDR_WIDTH = 23,
  parameter int                    DATA_WIDTH = 16,
  parameter int                    RAM_DEPTH  = 256,
  parameter logic [15:0]           CFG_BASE   = 16'h0100,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 16'hFFFF
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  input  logic [15:0]           config_addr,
  input  logic [15:0]           config_data,
  input  logic                  config_strobe,
  input  logic [ADDR_WIDTH-1:0] burst_addr,
  input  logic                  burst_addr_strobe,
  output logic                  patch_trigger,
  output logic [3:0]            patch_slot,
  output logic                  patch_active,
  output logic [DATA_WIDTH-1:0] patch_data,
  input  logic                  patch_data_next
);

  localparam int PW  = $clog2(RAM_DEPTH);
  localparam int AHI = ADDR_WIDTH - 16;

  // Per-slot configuration
  logic [ADDR_WIDTH-1:0] r_trig_addr [NUM_SLOTS];
  logic [PW-1:0]         r_start     [NUM_SLOTS];
  logic [PW:0]           r_len       [NUM_SLOTS];
  logic [NUM_SLOTS-1:0]  r_en;

  // Shared patch RAM and its pointers
  logic [DATA_WIDTH-1:0] r_ram [RAM_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [PW:0]           r_rem;

  // Output registers
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_active;
  logic [3:0]            r_slot;

  // Config decode; offsets below CFG_BASE wrap to large values and miss the map
  logic [15:0] w_cfg_off;
  logic        w_slot_wr;
  logic        w_wptr_wr;
  logic        w_ram_wr;

  assign w_cfg_off = config_addr - CFG_BASE;
  assign w_slot_wr = config_strobe && (w_cfg_off < 16'(4 * NUM_SLOTS));
  assign w_wptr_wr = config_strobe && (w_cfg_off == 16'h0040);
  assign w_ram_wr  = config_strobe && (w_cfg_off == 16'h0041);

  // Slot register writes
  // NOTE: state is updated with <= so every read in this cycle (including the
  // trigger match) still sees the pre-write value.
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_en <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_trig_addr[s] <= '0;
        r_start[s]     <= '0;
        r_len[s]       <= '0;
      end
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_slot_wr && (w_cfg_off[5:2] == 4'(s))) begin
          case (w_cfg_off[1:0])
            2'd0: r_trig_addr[s][15:0]           <= config_data;
            2'd1: r_trig_addr[s][ADDR_WIDTH-1:16] <= config_data[AHI-1:0];
            2'd2: r_start[s]                     <= config_data[PW-1:0];
            default: begin
              r_en[s]  <= config_data[15];
              r_len[s] <= config_data[PW:0];
            end
          endcase
        end
      end
    end
  end

  // RAM write pointer: explicit load or post-increment on each data write
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr <= '0;
    end else if (w_wptr_wr) begin
      r_wptr <= config_data[PW-1:0];
    end else if (w_ram_wr) begin
      r_wptr <= r_wptr + 1'b1;
    end
  end

  // Patch RAM storage
  // NOTE: no reset here; contents survive reset and the array can map onto RAM.
  always_ff @(posedge mclk) begin
    if (w_ram_wr) begin
      r_ram[r_wptr] <= config_data;
    end
  end

  // Priority match: lowest-index enabled slot whose address equals burst_addr
  logic          w_hit;
  logic [3:0]    w_hit_slot;
  logic [PW-1:0] w_hit_start;
  logic [PW:0]   w_hit_len;

  // NOTE: every output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    w_hit       = 1'b0;
    w_hit_slot  = '0;
    w_hit_start = '0;
    w_hit_len   = '0;
    for (int s = NUM_SLOTS - 1; s >= 0; s--) begin
      if (r_en[s] && (r_trig_addr[s] == burst_addr)) begin
        w_hit       = 1'b1;
        w_hit_slot  = 4'(s);
        w_hit_start = r_start[s];
        w_hit_len   = r_len[s];
      end
    end
  end

  assign patch_trigger = burst_addr_strobe && w_hit;

  // Patch stream: a trigger restarts from the slot start and beats a same-cycle advance
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= '0;
      r_active <= 1'b0;
      r_slot   <= '0;
      r_rptr   <= '0;
      r_rem    <= '0;
    end else if (patch_trigger) begin
      r_slot   <= w_hit_slot;
      r_rptr   <= w_hit_start + 1'b1;
      r_rem    <= (w_hit_len == '0) ? '0 : w_hit_len - 1'b1;
      r_data   <= (w_hit_len != '0) ? r_ram[w_hit_start] : FILL_WORD;
      r_active <= (w_hit_len != '0);
    end else if (patch_data_next) begin
      if (r_rem != '0) begin
        r_data <= r_ram[r_rptr];
        r_rptr <= r_rptr + 1'b1;
        r_rem  <= r_rem - 1'b1;
      end else begin
        r_data   <= FILL_WORD;
        r_active <= 1'b0;
      end
    end
  end

  assign patch_data   = r_data;
  assign patch_active = r_active;
  assign patch_slot   = r_slot;

endmodule

// File: tb/tb_patch_store_multi.sv
// Scoreboard bench for patch_store_multi: stimulus pushes hand-computed
// expectations; monitors pop and compare when the DUT presents a result.
module tb_patch_store_multi;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic [15:0] config_addr;
  logic [15:0] config_data;
  logic        config_strobe;
  logic [22:0] burst_addr;
  logic        burst_addr_strobe;
  logic        patch_trigger;
  logic [3:0]  patch_slot;
  logic        patch_active;
  logic [15:0] patch_data;
  logic        patch_data_next;

  patch_store_multi dut (
    .mclk              (mclk),
    .reset_n           (reset_n),
    .config_addr       (config_addr),
    .config_data       (config_data),
    .config_strobe     (config_strobe),
    .burst_addr        (burst_addr),
    .burst_addr_strobe (burst_addr_strobe),
    .patch_trigger     (patch_trigger),
    .patch_slot        (patch_slot),
    .patch_active      (patch_active),
    .patch_data        (patch_data),
    .patch_data_next   (patch_data_next)
  );

  always #5 mclk = ~mclk;

  typedef struct packed {
    logic [15:0] data;
    logic        active;
    logic [3:0]  slot;
  } out_t;

  out_t  q_out[$];
  string q_name[$];
  logic  q_trig[$];
  string q_tname[$];

  int   n_checks = 0;
  int   n_errors = 0;
  logic tb_evt   = 1'b0;
  event e_sample;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_out();
    out_t  e;
    string nm;
    if (q_out.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL unexpected_output: got data %0h active %0b slot %0d expected no output",
               patch_data, patch_active, patch_slot);
    end else begin
      e  = q_out.pop_front();
      nm = q_name.pop_front();
      check({nm, "_data"},   patch_data,   e.data);
      check({nm, "_active"}, patch_active, e.active);
      check({nm, "_slot"},   patch_slot,   e.slot);
    end
  endtask

  // An output update happens on any edge that saw a trigger or an advance
  always @(posedge mclk) tb_evt <= patch_trigger | patch_data_next;

  // Monitor: trigger is checked mid-cycle, stream outputs after the updating edge
  always @(negedge mclk) begin
    if (burst_addr_strobe) begin
      if (q_trig.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_strobe: got trigger %0b expected no strobe", patch_trigger);
      end else begin
        check({q_tname.pop_front(), "_trigger"}, patch_trigger, q_trig.pop_front());
      end
    end
    if (tb_evt) compare_out();
  end

  // Monitor: explicit sample points used while in reset
  always @(e_sample) compare_out();

  task automatic push_out(input string name, input logic [15:0] d, input logic a, input logic [3:0] s);
    out_t e;
    e.data   = d;
    e.active = a;
    e.slot   = s;
    q_out.push_back(e);
    q_name.push_back(name);
  endtask

  task automatic step(input string name, input logic s_en, input logic [22:0] a,
                      input logic nxt, input logic c_en, input logic [15:0] ca,
                      input logic [15:0] cd, input logic e_trig, input logic e_out,
                      input logic [15:0] e_data, input logic e_act, input logic [3:0] e_slot);
    if (s_en) begin
      q_trig.push_back(e_trig);
      q_tname.push_back(name);
    end
    if (e_out) push_out(name, e_data, e_act, e_slot);
    burst_addr_strobe = s_en;
    burst_addr        = a;
    patch_data_next   = nxt;
    config_strobe     = c_en;
    config_addr       = ca;
    config_data       = cd;
    @(posedge mclk);
    #1;
    burst_addr_strobe = 1'b0;
    patch_data_next   = 1'b0;
    config_strobe     = 1'b0;
  endtask

  task automatic cfg(input logic [15:0] ca, input logic [15:0] cd);
    step("cfg", 1'b0, '0, 1'b0, 1'b1, ca, cd, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic strobe(input string name, input logic [22:0] a, input logic trig,
                        input logic [15:0] d, input logic act, input logic [3:0] s);
    step(name, 1'b1, a, 1'b0, 1'b0, '0, '0, trig, trig, d, act, s);
  endtask

  task automatic adv(input string name, input logic [15:0] d, input logic act, input logic [3:0] s);
    step(name, 1'b0, '0, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1, d, act, s);
  endtask

  task automatic idle();
    step("idle", 1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    config_addr       = '0;
    config_data       = '0;
    config_strobe     = 1'b0;
    burst_addr        = '0;
    burst_addr_strobe = 1'b0;
    patch_data_next   = 1'b0;
    #12;
    push_out("reset", 16'h0000, 1'b0, 4'd0);
    -> e_sample;
    #11 reset_n = 1'b1;
    @(posedge mclk);
    #1;

    // Basic stream: RAM[0..3] and slot 0 at 7F70F0, start 0, len 3
    cfg(16'h0140, 16'h0000);
    cfg(16'h0141, 16'h1111);
    cfg(16'h0141, 16'h2222);
    cfg(16'h0141, 16'h3333);
    cfg(16'h0141, 16'h4444);
    cfg(16'h0100, 16'h70F0);
    cfg(16'h0101, 16'h007F);
    cfg(16'h0102, 16'h0000);
    cfg(16'h0103, 16'h8003);
    strobe("s0_trig", 23'h7F70F0, 1'b1, 16'h1111, 1'b1, 4'd0);
    adv("s0_w1", 16'h2222, 1'b1, 4'd0);
    adv("s0_w2", 16'h3333, 1'b1, 4'd0);
    adv("s0_end", 16'hFFFF, 1'b0, 4'd0);
    adv("s0_idle", 16'hFFFF, 1'b0, 4'd0);

    // Priority: slots 1 and 2 share address 000100
    cfg(16'h0104, 16'h0100);
    cfg(16'h0105, 16'h0000);
    cfg(16'h0106, 16'h0001);
    cfg(16'h0107, 16'h8002);
    cfg(16'h0108, 16'h0100);
    cfg(16'h0109, 16'h0000);
    cfg(16'h010A, 16'h0003);
    cfg(16'h010B, 16'h8001);
    strobe("prio_s1", 23'h000100, 1'b1, 16'h2222, 1'b1, 4'd1);
    cfg(16'h0107, 16'h0002);
    strobe("prio_s2", 23'h000100, 1'b1, 16'h4444, 1'b1, 4'd2);
    adv("prio_end", 16'hFFFF, 1'b0, 4'd2);
    strobe("nomatch", 23'h000101, 1'b0, '0, 1'b0, '0);
    strobe("hi_bits", 23'h0070F0, 1'b0, '0, 1'b0, '0);

    // Wrap: RAM[254,255,0,1]=A,B,C,D then E lands at RAM[2]
    cfg(16'h0140, 16'h00FE);
    cfg(16'h0141, 16'hAAAA);
    cfg(16'h0141, 16'hBBBB);
    cfg(16'h0141, 16'hCCCC);
    cfg(16'h0141, 16'hDDDD);
    cfg(16'h0141, 16'hEEEE);
    cfg(16'h010C, 16'h3456);
    cfg(16'h010D, 16'h0012);
    cfg(16'h010E, 16'h00FE);
    cfg(16'h010F, 16'h8004);
    strobe("wrap_a", 23'h123456, 1'b1, 16'hAAAA, 1'b1, 4'd3);
    adv("wrap_b", 16'hBBBB, 1'b1, 4'd3);
    adv("wrap_c", 16'hCCCC, 1'b1, 4'd3);
    adv("wrap_d", 16'hDDDD, 1'b1, 4'd3);
    adv("wrap_end", 16'hFFFF, 1'b0, 4'd3);
    cfg(16'h010A, 16'h0002);
    strobe("wptr_wrap", 23'h000100, 1'b1, 16'hEEEE, 1'b1, 4'd2);

    // Retrigger with same-cycle advance: trigger wins
    strobe("re_a", 23'h123456, 1'b1, 16'hAAAA, 1'b1, 4'd3);
    adv("re_b", 16'hBBBB, 1'b1, 4'd3);
    step("re_trig_next", 1'b1, 23'h7F70F0, 1'b1, 1'b0, '0, '0, 1'b1, 1'b1, 16'hCCCC, 1'b1, 4'd0);
    adv("re_w1", 16'hDDDD, 1'b1, 4'd0);
    adv("re_w2", 16'hEEEE, 1'b1, 4'd0);
    adv("re_end", 16'hFFFF, 1'b0, 4'd0);

    // Length-0 slot
    cfg(16'h010B, 16'h8000);
    strobe("len0", 23'h000100, 1'b1, 16'hFFFF, 1'b0, 4'd2);
    adv("len0_adv", 16'hFFFF, 1'b0, 4'd2);

    // Same-cycle config write vs match uses pre-write slot state
    step("pre_en", 1'b1, 23'h000100, 1'b0, 1'b1, 16'h0107, 16'h8002, 1'b1, 1'b1, 16'hFFFF, 1'b0, 4'd2);
    strobe("post_en", 23'h000100, 1'b1, 16'hDDDD, 1'b1, 4'd1);
    adv("post_en_w1", 16'hEEEE, 1'b1, 4'd1);
    adv("post_en_end", 16'hFFFF, 1'b0, 4'd1);
    step("pre_dis", 1'b1, 23'h123456, 1'b0, 1'b1, 16'h010F, 16'h0004, 1'b1, 1'b1, 16'hAAAA, 1'b1, 4'd3);
    strobe("post_dis", 23'h123456, 1'b0, '0, 1'b0, '0);

    // Writes outside the window change nothing
    cfg(16'h00FF, 16'h0000);
    cfg(16'h0110, 16'h0000);
    cfg(16'h1103, 16'h0000);
    cfg(16'h0040, 16'h0000);
    cfg(16'h0142, 16'h0000);
    strobe("oow_trig", 23'h7F70F0, 1'b1, 16'hCCCC, 1'b1, 4'd0);
    adv("oow_w1", 16'hDDDD, 1'b1, 4'd0);
    cfg(16'h0141, 16'h5555);
    cfg(16'h0106, 16'h0003);
    strobe("oow_wptr", 23'h000100, 1'b1, 16'h5555, 1'b1, 4'd1);

    // Asynchronous reset mid-stream
    strobe("rst_pre", 23'h7F70F0, 1'b1, 16'hCCCC, 1'b1, 4'd0);
    adv("rst_pre_w1", 16'hDDDD, 1'b1, 4'd0);
    idle();
    #2 reset_n = 1'b0;
    #1;
    push_out("midrst", 16'h0000, 1'b0, 4'd0);
    -> e_sample;
    #10 reset_n = 1'b1;
    @(posedge mclk);
    #1;
    strobe("rst_cleared", 23'h7F70F0, 1'b0, '0, 1'b0, '0);
    cfg(16'h0100, 16'h70F0);
    cfg(16'h0101, 16'h007F);
    cfg(16'h0102, 16'h0000);
    cfg(16'h0103, 16'h8003);
    strobe("rst_reprog", 23'h7F70F0, 1'b1, 16'hCCCC, 1'b1, 4'd0);

    repeat (3) idle();
    check("sb_out_drained", q_out.size(), 0);
    check("sb_trig_drained", q_trig.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
